display_scheduler: RTL and testbench
====================================

DISPLAY_SCHEDULER -- requirements
Module: display_scheduler

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 100000, meaning clk cycles per digit scan tick (minimum 2).
REQ-002 The block SHALL have parameter HOLD_FRAMES, default 64, meaning minimum full 4-digit frames an owner keeps the display when contended (minimum 1).
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 The block SHALL have port req  input  4  per-requester display request, bit i = requester i.
REQ-006 The block SHALL have ports val0, val1, val2, val3  input  16 each  value requester i wants shown.
REQ-007 The block SHALL have port lock  input  1  when high, the current owner is not pre-empted.
REQ-008 The block SHALL have port grant  output  4  one-hot owner indication, or all zero when idle.
REQ-009 The block SHALL have port an  output  4  active-low digit anode enables.
REQ-010 The block SHALL have port nibble  output  4  hex digit for the currently enabled anode, to be fed to the external decoder.
REQ-011 The block SHALL have port frame  output  1  one-cycle pulse at each frame boundary.

Function
REQ-012 Tick: a counter SHALL count 0..CLK_DIV-1 and wrap; tick is high for the one cycle the counter equals CLK_DIV-1.
REQ-013 Scan: a 2-bit index idx SHALL advance by 1 on each tick, wrapping 3->0; frame SHALL pulse on the tick where idx==3.
REQ-014 Anti-ghost: an SHALL be 4'b1111 in the cycle after every tick; otherwise, while owned, an SHALL equal the bitwise inverse of (1<<idx).
REQ-015 nibble SHALL be val_owner[4*idx+3:4*idx], with val sampled live every cycle; it SHALL be 4'h0 when idle.
REQ-016 Arbiter FSM SHALL have two states: IDLE (grant=0, an=4'b1111) and OWN (grant one-hot).
REQ-017 IDLE->OWN SHALL occur only on a frame pulse with req!=0; the winner SHALL be the first set req bit searching round-robin from last_owner+1 mod 4.
REQ-018 In OWN, if req[owner]==0, the FSM SHALL go to IDLE on the next edge (grant cleared), regardless of tick or frame.
REQ-019 In OWN, a frame-boundary dwell counter SHALL count frames since grant, saturating at HOLD_FRAMES.
REQ-020 In OWN, on a frame pulse with dwell>=HOLD_FRAMES, lock==0 and another req bit set, ownership SHALL move to the round-robin next requester, and dwell SHALL reset to 0.
REQ-021 If no other requester is pending, or lock==1, the owner SHALL retain the display indefinitely.
REQ-022 If req[owner] falls on a frame-pulse cycle and others are requesting, the block SHALL grant directly to the round-robin next requester (OWN->OWN), skipping IDLE.
REQ-023 last_owner SHALL update on every grant; grant changes SHALL take effect on the edge following the deciding cycle, and idx SHALL be unaffected by arbitration.

Reset
REQ-024 While rst_n==0 at a clk edge, the block SHALL set the tick counter=0, idx=0, state=IDLE, last_owner=3, dwell=0, grant=4'b0000, an=4'b1111, nibble=4'h0 and frame=0.
REQ-025 Reset asserted mid-operation SHALL abandon the owner without completing the frame; after release, the first grant SHALL occur at the first frame pulse, at the earliest after 4*CLK_DIV cycles.

Verification (CLK_DIV=4, HOLD_FRAMES=2)
REQ-026 Reset, then req=4'b0001, val0=16'h1234: grant=4'b0001 after the first frame pulse (cycle 16); nibble cycles 4,3,2,1 with an 1110,1101,1011,0111; an=1111 for the one cycle after each tick.
REQ-027 req=4'b0011 held, val1=16'hABCD: owner 0 for 2 frames; on the next frame pulse grant becomes 4'b0010 and nibbles become D,C,B,A; after 2 more frames grant returns to 4'b0001.
REQ-028 As REQ-027 with lock=1: grant stays 4'b0001 for at least 10 frames; after lock is lowered, grant moves to 4'b0010 at the next frame pulse.
REQ-029 Owner 2 drops req mid-frame with req=4'b1000 pending: grant=0 and an=1111 on the next edge; grant=4'b1000 at the following frame pulse.
REQ-030 rst_n low for 1 cycle while owned at idx=2: all outputs equal their REQ-024 values on the next edge, and no grant is issued until the first post-reset frame pulse.

Source files
------------

// File: rtl/display_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : display_scheduler
//  Description : Time-multiplexed 4-digit hex display driver shared between
//                four requesters. A clock divider produces a scan tick, a
//                2-bit index walks the digits, and a two-state arbiter hands
//                the display to one requester at a time. Ownership changes
//                only on frame boundaries, except that an owner dropping its
//                request releases the display on the next edge.
//  Ports       : clk            - clock, all state on rising edge
//                rst_n          - synchronous active-low reset
//                req[3:0]       - per-requester display request
//                val0..val3     - 16-bit value each requester wants shown
//                lock           - holds the current owner against pre-emption
//                grant[3:0]     - one-hot owner, zero when idle
//                an[3:0]        - active-low digit anode enables
//                nibble[3:0]    - hex digit for the enabled anode
//                frame          - one-cycle pulse at each frame boundary
//  Revision    : 1.0 - initial release
// ============================================================================
module display_scheduler #(
   parameter int CLK_DIV     = 100000,
   parameter int HOLD_FRAMES = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  req,
   input  logic [15:0] val0,
   input  logic [15:0] val1,
   input  logic [15:0] val2,
   input  logic [15:0] val3,
   input  logic        lock,
   output logic [3:0]  grant,
   output logic [3:0]  an,
   output logic [3:0]  nibble,
   output logic        frame
);

   localparam int CNT_W   = $clog2(CLK_DIV);
   localparam int DWELL_W = $clog2(HOLD_FRAMES + 1);

   localparam logic [CNT_W-1:0]   c_TICK_LAST = CNT_W'(CLK_DIV - 1);
   localparam logic [DWELL_W-1:0] c_HOLD      = DWELL_W'(HOLD_FRAMES);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_OWN  = 1'b1
   } state_t;

   // Round-robin search: first set request strictly after 'last', wrapping
   // around so that 'last' itself is considered only at the very end.
   function automatic logic [1:0] rr_next(input logic [3:0] r, input logic [1:0] last);
      logic [1:0] cand;
      logic [1:0] sel;
      logic       found;
      sel   = last + 2'd1;
      found = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         cand = last + 2'(k);
         if (!found && r[cand]) begin
            sel   = cand;
            found = 1'b1;
         end
      end
      return sel;
   endfunction

   logic [CNT_W-1:0]   cnt_q;
   logic [1:0]         idx_q;
   logic               blank_q;
   state_t             state_q,  state_d;
   logic [1:0]         owner_q,  owner_d;
   logic [1:0]         last_q,   last_d;
   logic [DWELL_W-1:0] dwell_q,  dwell_d;

   logic        w_tick;
   logic        w_frame;
   logic [1:0]  w_pick;
   logic [3:0]  w_owner_oh;
   logic        w_others;
   logic [15:0] w_val;

   assign w_tick     = (cnt_q == c_TICK_LAST);
   assign w_frame    = w_tick && (idx_q == 2'd3);
   assign w_pick     = rr_next(req, last_q);
   assign w_owner_oh = 4'b0001 << owner_q;
   assign w_others   = |(req & ~w_owner_oh);

   // ------------------------------------------------------------------------
   // Scan timing: divider, digit index and the one-cycle anti-ghost blank.
   // Arbitration never touches these.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         idx_q   <= 2'd0;
         blank_q <= 1'b0;
      end else begin
         cnt_q   <= w_tick ? '0 : cnt_q + CNT_W'(1);
         blank_q <= w_tick;
         if (w_tick) begin
            idx_q <= idx_q + 2'd1;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Arbiter state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         owner_q <= 2'd0;
         last_q  <= 2'd3;
         dwell_q <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         dwell_q <= dwell_d;
      end
   end

   // ------------------------------------------------------------------------
   // Arbiter next state
   // ------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      dwell_d = dwell_q;
      case (state_q)
         S_IDLE: begin
            if (w_frame && (req != 4'b0000)) begin
               state_d = S_OWN;
               owner_d = w_pick;
               last_d  = w_pick;
               dwell_d = '0;
            end
         end
         S_OWN: begin
            if (!req[owner_q]) begin
               // A release landing on a frame boundary with others waiting
               // hands over directly instead of idling for a whole frame.
               if (w_frame && w_others) begin
                  owner_d = w_pick;
                  last_d  = w_pick;
                  dwell_d = '0;
               end else begin
                  state_d = S_IDLE;
               end
            end else if (w_frame) begin
               if ((dwell_q >= c_HOLD) && !lock && w_others) begin
                  owner_d = w_pick;
                  last_d  = w_pick;
                  dwell_d = '0;
               end else if (dwell_q < c_HOLD) begin
                  dwell_d = dwell_q + DWELL_W'(1);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // Outputs: value is sampled live, so nibble follows val changes at once.
   // ------------------------------------------------------------------------
   always_comb begin
      case (owner_q)
         2'd0:    w_val = val0;
         2'd1:    w_val = val1;
         2'd2:    w_val = val2;
         default: w_val = val3;
      endcase
   end

   always_comb begin
      grant  = 4'b0000;
      an     = 4'b1111;
      nibble = 4'h0;
      frame  = w_frame;
      if (state_q == S_OWN) begin
         grant = w_owner_oh;
         if (!blank_q) begin
            an = ~(4'b0001 << idx_q);
         end
         case (idx_q)
            2'd0:    nibble = w_val[3:0];
            2'd1:    nibble = w_val[7:4];
            2'd2:    nibble = w_val[11:8];
            default: nibble = w_val[15:12];
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_display_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_display_scheduler
//  Description : Self-checking bench for display_scheduler (CLK_DIV=4,
//                HOLD_FRAMES=2). A cycle-number based reference model is
//                compared against every output each cycle; directed
//                scenarios add literal expectations at fixed cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_display_scheduler;

   localparam int D = 4;
   localparam int H = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req;
   logic [15:0] val [4];
   logic        lock;
   logic [3:0]  grant;
   logic [3:0]  an;
   logic [3:0]  nibble;
   logic        frame;

   int n_checks = 0;
   int n_fail   = 0;
   int tcyc     = 0;

   // reference model state
   bit m_valid = 1'b0;
   int m_cyc, m_owner, m_last, m_fs;

   display_scheduler #(.CLK_DIV(D), .HOLD_FRAMES(H)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .req    (req),
      .val0   (val[0]),
      .val1   (val[1]),
      .val2   (val[2]),
      .val3   (val[3]),
      .lock   (lock),
      .grant  (grant),
      .an     (an),
      .nibble (nibble),
      .frame  (frame)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   function automatic int rr(input logic [3:0] r, input int last);
      for (int k = 1; k <= 4; k++) begin
         if (r[(last + k) % 4]) return (last + k) % 4;
      end
      return -1;
   endfunction

   // ------------------------------------------------------------------------
   // Reference model: compare current cycle, then advance using the inputs
   // the DUT will sample on the coming rising edge.
   // ------------------------------------------------------------------------
   always @(negedge clk) begin
      int  e_idx;
      bit  e_tick, e_frame, e_blank, others;
      logic [3:0] e_grant, e_an, e_nib;
      e_idx   = (m_cyc / D) % 4;
      e_tick  = (m_cyc % D) == D - 1;
      e_frame = e_tick && (e_idx == 3);
      if (m_valid) begin
         e_blank = (m_cyc > 0) && (m_cyc % D == 0);
         e_grant = (m_owner < 0) ? 4'h0 : 4'(1 << m_owner);
         e_an    = (m_owner < 0 || e_blank) ? 4'hF : ~4'(1 << e_idx);
         e_nib   = (m_owner < 0) ? 4'h0 : 4'((val[m_owner] >> (4 * e_idx)) & 16'hF);
         chk("model_grant",  grant,        e_grant);
         chk("model_an",     an,           e_an);
         chk("model_nibble", nibble,       e_nib);
         chk("model_frame",  {3'b0, frame}, {3'b0, e_frame});
      end
      if (!rst_n) begin
         m_valid = 1'b1;
         m_cyc   = 0;
         m_owner = -1;
         m_last  = 3;
         m_fs    = 0;
      end else if (m_valid) begin
         others = 1'b0;
         for (int j = 0; j < 4; j++) if (j != m_owner && req[j]) others = 1'b1;
         if (m_owner < 0) begin
            if (e_frame && req != 4'h0) begin
               m_owner = rr(req, m_last); m_last = m_owner; m_fs = 0;
            end
         end else if (!req[m_owner]) begin
            if (e_frame && others) begin
               m_owner = rr(req, m_last); m_last = m_owner; m_fs = 0;
            end else begin
               m_owner = -1;
            end
         end else if (e_frame) begin
            if (m_fs >= H && !lock && others) begin
               m_owner = rr(req, m_last); m_last = m_owner; m_fs = 0;
            end else begin
               m_fs++;
            end
         end
         m_cyc++;
      end
   end

   task automatic do_reset();
      @(posedge clk); #1 rst_n = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      #1;
      tcyc = 0;
   endtask

   task automatic goto(input int n);
      while (tcyc < n) begin
         @(posedge clk);
         tcyc++;
      end
      #2;
   endtask

   initial begin
      rst_n = 1'b0; req = 4'h0; lock = 1'b0;
      for (int i = 0; i < 4; i++) val[i] = 16'h0;
      repeat (3) @(posedge clk);

      // single requester, digit scan
      req = 4'b0001; val[0] = 16'h1234;
      do_reset();
      chk("rst_grant", grant, 4'h0);
      chk("rst_an", an, 4'hF);
      chk("rst_nibble", nibble, 4'h0);
      chk("rst_frame", {3'b0, frame}, 4'h0);
      goto(15); chk("first_frame", {3'b0, frame}, 4'h1); chk("pre_grant", grant, 4'h0);
      goto(16); chk("grant0", grant, 4'b0001); chk("blank16", an, 4'hF);
      goto(17); chk("nib_d0", nibble, 4'h4); chk("an_d0", an, 4'b1110);
      goto(20); chk("blank20", an, 4'hF);
      goto(21); chk("nib_d1", nibble, 4'h3); chk("an_d1", an, 4'b1101);
      goto(25); chk("nib_d2", nibble, 4'h2); chk("an_d2", an, 4'b1011);
      goto(29); chk("nib_d3", nibble, 4'h1); chk("an_d3", an, 4'b0111);

      // two contenders, hold then rotate
      req = 4'b0011; val[1] = 16'hABCD;
      do_reset();
      goto(63);  chk("hold_owner0", grant, 4'b0001);
      goto(64);  chk("rotate_to1", grant, 4'b0010);
      goto(65);  chk("rotate_nib", nibble, 4'hD);
      goto(111); chk("hold_owner1", grant, 4'b0010);
      goto(112); chk("rotate_back", grant, 4'b0001);

      // lock holds owner
      lock = 1'b1;
      do_reset();
      goto(176); chk("lock_hold", grant, 4'b0001);
      goto(180); lock = 1'b0;
      goto(191); chk("unlock_pre", grant, 4'b0001);
      goto(192); chk("unlock_move", grant, 4'b0010);

      // owner drops mid-frame, then reset while owned
      req = 4'b0100; val[2] = 16'h5678; val[3] = 16'h9ABC;
      do_reset();
      goto(16); chk("own2", grant, 4'b0100);
      goto(20); req = 4'b1000;
      goto(21); chk("drop_grant", grant, 4'h0); chk("drop_an", an, 4'hF);
      goto(31); chk("idle_wait", grant, 4'h0);
      goto(32); chk("own3", grant, 4'b1000);
      goto(41);
      do_reset();
      chk("mid_rst_grant", grant, 4'h0);
      chk("mid_rst_an", an, 4'hF);
      chk("mid_rst_nib", nibble, 4'h0);
      chk("mid_rst_frame", {3'b0, frame}, 4'h0);
      goto(15); chk("post_rst_wait", grant, 4'h0);
      goto(16); chk("post_rst_grant", grant, 4'b1000);

      // randomized traffic against the model
      for (int c = 0; c < 6000; c++) begin
         @(posedge clk); #1;
         for (int i = 0; i < 4; i++) val[i] = 16'($urandom);
         if ($urandom_range(0, 39) == 0) req = 4'($urandom);
         if ($urandom_range(0, 59) == 0) lock = 1'($urandom);
         rst_n = ($urandom_range(0, 1499) != 0);
      end
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #2;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
